hazard_unit: RTL and testbench
==============================

// Module: hazard_unit
// PURPOSE
//  Consumer of the decode stage's operand-need/result-ready stage tags. Tracks the destination register
//  and write stage of every in-flight instruction in E/M/W. Emits the D-stage stall and the forwarding
//  selects for the D, E and M operand ports. Sits beside the 5-stage pipeline; owns no datapath values.
// PARAMETERS
//  none (stage and forwarding encodings come from def.v)
// PORTS
//  clk            in   1  single clock; all state updates on posedge
//  reset          in   1  synchronous, active-high; clears all tracks
//  d_read_addr0   in   5  rs of instr in D
//  d_read_addr1   in   5  rt of instr in D
//  d_read_stage0  in   2  stage that first uses rs; STAGE_MAX = unused
//  d_read_stage1  in   2  stage that first uses rt; STAGE_MAX = unused
//  d_write_addr   in   5  destination of instr in D; 0 = no write
//  d_write_stage  in   2  stage whose end produces the result
//  stall          out  1  hold PC and F/D register, inject bubble into E
//  fwd_d0/fwd_d1  out  2  forward select for D-stage rs/rt (branch/jr compare)
//  fwd_e0/fwd_e1  out  2  forward select for E-stage rs/rt (ALU)
//  fwd_m1         out  2  forward select for M-stage rt (store data)
// BEHAVIOUR
//  - Stage positions: D=0, E=1, M=2, W=3 (STAGE_DECODE/EXECUTE/MEM = 0/1/2, STAGE_MAX = 3).
//  - Tracks: {waddr, wstage} for E, M, W; {raddr0, raddr1, rstage0, rstage1} for E, M.
//  - Each clk: reset -> all tracks waddr=0, raddr=0, rstage=STAGE_MAX.
//    stall -> E <= bubble (as reset values), M <= E, W <= M.
//    else -> E <= D inputs, M <= E, W <= M.
//  - A producer at position P matches a read of addr a iff waddr==a && a!=0. Reads of $0 never forward
//    or stall.
//  - Nearest match wins: for a consumer at position C, search P = C+1..3 in ascending order. The first
//    match decides; older producers are ignored.
//  - Ready rule: the producer at P holds its result in its pipeline register iff wstage < P.
//  - fwd_* = FWD_FROM_E/M/W (1/2/3) when the nearest match is ready, else FWD_NONE (0).
//    FWD_NONE also applies for no match.
//  - Port searches: fwd_d* searches E,M,W. fwd_e* searches M,W. fwd_m1 searches W.
//  - fwd_e*/fwd_m1 use the pipelined read addresses. An unready nearest match at E/M is impossible by
//    construction of stall; the output is FWD_NONE.
//  - Stall, per D port i with rstage R != STAGE_MAX: find the nearest match P in E,M,W.
//    Stall iff wstage >= R + P. Stall = OR over both ports. The W position never stalls.
//  - Examples: lw(MEM) in E vs add(R=EXECUTE) -> 2>=2 stall. add in E vs beq(R=DECODE) -> 1>=1 stall.
//    jal(DECODE) in E vs jr -> 0>=1 no stall, forward E.
//  - stall and fwd_* are combinational from the tracks and D inputs, so latency 0. Tracks update 1 cycle later.
//  - Reset mid-stall: the cycle after reset has all tracks empty, stall=0 and all fwd=FWD_NONE, whatever
//    the D inputs.
//  - Reset values: stall=0, all fwd_*=FWD_NONE when D reads are unused.
// CONFIGURATION
//  HAZARD_MDU_EN: defined -> adds inputs d_md_start (1, D instr starts mult/div), d_md_use
//   (1, D instr accesses HI/LO or starts mult/div) and md_busy (1, MDU computing). Adds an E track
//   e_md_start, cleared by reset/bubble. Stall also asserts iff d_md_use && (md_busy || e_md_start).
//  Undefined -> no such ports or track; stall is data-hazard only.
// STRUCTURE
//  - def.v holds the shared constants STAGE_DECODE/EXECUTE/MEM/MAX and FWD_NONE/FROM_E/FROM_M/FROM_W
//    (2 bits).
//  - Sub-module hazard_match (combinational): inputs are a read addr, a consumer position and the
//    producer tracks. Outputs are the fwd select and a "nearest match not ready by R" flag.
//  - hazard_match is instantiated per read port. The top holds the track registers and the optional MDU logic.
// TESTING
//  1. lw $8 then add $9,$8,$8: stall=1 for exactly 1 cycle (lw in E), then fwd_e0=fwd_e1=FWD_FROM_W.
//  2. addu $8 then beq $8,$0: stall=1 for 1 cycle, next cycle fwd_d0=FWD_FROM_M, fwd_d1=FWD_NONE.
//  3. lw $8 then sw $8,0($9): stall never asserts; fwd_e0=FWD_NONE. When sw is in M, fwd_m1=FWD_FROM_W.
//  4. jal then jr $31: stall=0, fwd_d0=FWD_FROM_E. addu $0,$1,$1 then add $2,$0,$0: no stall, all FWD_NONE.
//  5. ori $8 (E), addu $8 (M), beq $8,$8 in D: nearest is ori in E -> stall=1. Next cycle fwd_d0=FWD_FROM_M.
//  6. reset asserted during the lw->add stall: next cycle stall=0, all fwd_*=FWD_NONE.
//     With HAZARD_MDU_EN, mult then mfhi: stall while md_busy=1, release on the same cycle md_busy falls.

Source files
------------

// File: rtl/hazard_unit_pkg.sv
// Shared stage/forwarding encodings and track record types for the hazard unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package hazard_unit_pkg;

    // Pipeline positions; STAGE_MAX doubles as "operand unused".
    localparam logic [1:0] STAGE_DECODE  = 2'd0;
    localparam logic [1:0] STAGE_EXECUTE = 2'd1;
    localparam logic [1:0] STAGE_MEM     = 2'd2;
    localparam logic [1:0] STAGE_MAX     = 2'd3;

    // Forwarding selects: the value equals the producer position it comes from.
    localparam logic [1:0] FWD_NONE   = 2'd0;
    localparam logic [1:0] FWD_FROM_E = 2'd1;
    localparam logic [1:0] FWD_FROM_M = 2'd2;
    localparam logic [1:0] FWD_FROM_W = 2'd3;

    typedef logic [4:0] reg_addr_t;
    typedef logic [1:0] stage_t;
    typedef logic [1:0] fwd_t;

    // Producer side of an in-flight instruction.
    typedef struct packed {
        reg_addr_t waddr;
        stage_t    wstage;
    } prod_t;

    // Consumer side of an in-flight instruction.
    typedef struct packed {
        reg_addr_t raddr0;
        reg_addr_t raddr1;
        stage_t    rstage0;
        stage_t    rstage1;
    } cons_t;

    // Empty slot: also what a bubble looks like.
    localparam prod_t PROD_EMPTY = '{waddr: 5'd0, wstage: STAGE_DECODE};
    localparam cons_t CONS_EMPTY = '{raddr0: 5'd0, raddr1: 5'd0,
                                     rstage0: STAGE_MAX, rstage1: STAGE_MAX};

    // $0 is hard-wired, so a read of it never depends on anything in flight.
    function automatic logic addr_match(reg_addr_t waddr, reg_addr_t raddr);
        return (raddr != 5'd0) && (waddr == raddr);
    endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// D-stage operand/result tags in, stall and forwarding selects out; HAZARD_MDU_EN adds MDU tags.
// Latency: n/a (wiring only).
// Backpressure: stall is the only backpressure, asserted by the hazard unit toward the pipeline.
interface hazard_unit_if;
    import hazard_unit_pkg::*;

    reg_addr_t d_read_addr0;
    reg_addr_t d_read_addr1;
    stage_t    d_read_stage0;
    stage_t    d_read_stage1;
    reg_addr_t d_write_addr;
    stage_t    d_write_stage;
`ifdef HAZARD_MDU_EN
    logic      d_md_start;
    logic      d_md_use;
    logic      md_busy;
`endif
    logic      stall;
    fwd_t      fwd_d0;
    fwd_t      fwd_d1;
    fwd_t      fwd_e0;
    fwd_t      fwd_e1;
    fwd_t      fwd_m1;

    // Pipeline side: publishes decode tags, obeys stall and forwarding selects.
    modport master (
`ifdef HAZARD_MDU_EN
        output d_md_start, d_md_use, md_busy,
`endif
        output d_read_addr0, d_read_addr1, d_read_stage0, d_read_stage1,
        output d_write_addr, d_write_stage,
        input  stall, fwd_d0, fwd_d1, fwd_e0, fwd_e1, fwd_m1
    );

    // Hazard unit side.
    modport slave (
`ifdef HAZARD_MDU_EN
        input  d_md_start, d_md_use, md_busy,
`endif
        input  d_read_addr0, d_read_addr1, d_read_stage0, d_read_stage1,
        input  d_write_addr, d_write_stage,
        output stall, fwd_d0, fwd_d1, fwd_e0, fwd_e1, fwd_m1
    );

endinterface

// File: rtl/hazard_unit_match.sv
// Nearest-producer search for one read port: forwarding select plus "result too late" flag.
// Latency: 0 cycles, purely combinational.
// Backpressure: none; the late flag feeds the stall decision in the top.
module hazard_match
    import hazard_unit_pkg::*;
(
    input  reg_addr_t   rd_addr,    // register being read
    input  stage_t      rd_stage,   // stage that first needs it; STAGE_MAX = unused
    input  stage_t      cons_pos,   // position of the consumer (D=0, E=1, M=2)
    input  prod_t [3:1] prod,       // producer tracks indexed by position E=1, M=2, W=3
    output fwd_t        fwd_sel,
    output logic        not_ready
);

    // Walk from oldest to youngest so the nearest matching producer overwrites older ones.
    always_comb begin
        fwd_sel   = FWD_NONE;
        not_ready = 1'b0;
        for (int p = 3; p >= 1; p--) begin
            if ((2'(p) > cons_pos) && addr_match(prod[p].waddr, rd_addr)) begin
                // Result sits in the pipeline register at p once its write stage is behind p.
                fwd_sel   = (prod[p].wstage < 2'(p)) ? 2'(p) : FWD_NONE;
                // Too late if it is produced no earlier than the point the consumer needs it;
                // a producer already in W has always finished.
                not_ready = (p != 3) && (rd_stage != STAGE_MAX) &&
                            ({1'b0, prod[p].wstage} >= ({1'b0, rd_stage} + 3'(p)));
            end
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Tracks E/M/W destination tags and drives D stall plus D/E/M forwarding selects (HAZARD_MDU_EN adds MDU stall).
// Latency: stall/fwd are combinational (0 cycles); tracks advance one cycle later.
// Backpressure: stall holds PC and F/D and injects a bubble into E; W never causes a stall.
module hazard_unit
    import hazard_unit_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    hazard_unit_if.slave  hz
);

    prod_t e_prod_q, e_prod_d;
    prod_t m_prod_q, m_prod_d;
    prod_t w_prod_q, w_prod_d;
    cons_t e_cons_q, e_cons_d;
    cons_t m_cons_q, m_cons_d;

    prod_t [3:1] prod_trk;
    logic        stall;
    logic        d0_late, d1_late;
    logic        e0_late, e1_late, m1_late;
    logic        md_stall;

    assign prod_trk = {w_prod_q, m_prod_q, e_prod_q};

    // D-stage rs/rt: search E, M, W; also decide whether the result arrives too late.
    hazard_match u_match_d0 (
        .rd_addr   (hz.d_read_addr0),
        .rd_stage  (hz.d_read_stage0),
        .cons_pos  (STAGE_DECODE),
        .prod      (prod_trk),
        .fwd_sel   (hz.fwd_d0),
        .not_ready (d0_late)
    );

    hazard_match u_match_d1 (
        .rd_addr   (hz.d_read_addr1),
        .rd_stage  (hz.d_read_stage1),
        .cons_pos  (STAGE_DECODE),
        .prod      (prod_trk),
        .fwd_sel   (hz.fwd_d1),
        .not_ready (d1_late)
    );

    // E-stage ALU operands: search M, W using the pipelined read addresses.
    hazard_match u_match_e0 (
        .rd_addr   (e_cons_q.raddr0),
        .rd_stage  (STAGE_MAX),
        .cons_pos  (STAGE_EXECUTE),
        .prod      (prod_trk),
        .fwd_sel   (hz.fwd_e0),
        .not_ready (e0_late)
    );

    hazard_match u_match_e1 (
        .rd_addr   (e_cons_q.raddr1),
        .rd_stage  (STAGE_MAX),
        .cons_pos  (STAGE_EXECUTE),
        .prod      (prod_trk),
        .fwd_sel   (hz.fwd_e1),
        .not_ready (e1_late)
    );

    // M-stage store data: only W can still be ahead of it.
    hazard_match u_match_m1 (
        .rd_addr   (m_cons_q.raddr1),
        .rd_stage  (STAGE_MAX),
        .cons_pos  (STAGE_MEM),
        .prod      (prod_trk),
        .fwd_sel   (hz.fwd_m1),
        .not_ready (m1_late)
    );

`ifdef HAZARD_MDU_EN
    logic e_md_start_q, e_md_start_d;

    // A HI/LO access must wait while the MDU runs or a mult/div is about to launch from E.
    always_comb begin
        md_stall     = hz.d_md_use && (hz.md_busy || e_md_start_q);
        e_md_start_d = stall ? 1'b0 : hz.d_md_start;
    end

    // E-stage MDU-start track.
    always_ff @(posedge clk) begin
        if (reset) begin
            e_md_start_q <= 1'b0;
        end else begin
            e_md_start_q <= e_md_start_d;
        end
    end
`else
    assign md_stall = 1'b0;
`endif

    assign stall    = d0_late | d1_late | md_stall;
    assign hz.stall = stall;

    // Next track contents: D enters E unless stalled (bubble), older entries shift down.
    always_comb begin
        e_prod_d = '{waddr: hz.d_write_addr, wstage: hz.d_write_stage};
        e_cons_d = '{raddr0: hz.d_read_addr0, raddr1: hz.d_read_addr1,
                     rstage0: hz.d_read_stage0, rstage1: hz.d_read_stage1};
        m_prod_d = e_prod_q;
        m_cons_d = e_cons_q;
        w_prod_d = m_prod_q;
        if (stall) begin
            e_prod_d = PROD_EMPTY;
            e_cons_d = CONS_EMPTY;
        end
    end

    // Track registers with synchronous reset to empty slots.
    always_ff @(posedge clk) begin
        if (reset) begin
            e_prod_q <= PROD_EMPTY;
            m_prod_q <= PROD_EMPTY;
            w_prod_q <= PROD_EMPTY;
            e_cons_q <= CONS_EMPTY;
            m_cons_q <= CONS_EMPTY;
        end else begin
            e_prod_q <= e_prod_d;
            m_prod_q <= m_prod_d;
            w_prod_q <= w_prod_d;
            e_cons_q <= e_cons_d;
            m_cons_q <= m_cons_d;
        end
    end

    // Read stages of E/M, M's rs and the downstream late flags are carried but have no consumer.
    logic unused_ok;
    assign unused_ok = ^{e0_late, e1_late, m1_late,
                         e_cons_q.rstage0, e_cons_q.rstage1,
                         m_cons_q.raddr0, m_cons_q.rstage0, m_cons_q.rstage1};

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: expected outputs are queued per cycle and drained at the falling edge.
// Latency: outputs are checked in the same cycle the D inputs are applied.
// Backpressure: the bench holds the D instruction while it expects stall.
module tb_hazard_unit;
    import hazard_unit_pkg::*;

    localparam int SD = 0, SE = 1, SM = 2, SX = 3;
    localparam int FN = 0, FE = 1, FM = 2, FW = 3;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    hazard_unit_if hif();

    hazard_unit dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hif)
    );

    typedef enum int {O_STALL, O_D0, O_D1, O_E0, O_E1, O_M1} out_e;
    typedef struct {
        string tag;
        out_e  which;
        int    val;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check_val(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] observe(out_e w);
        case (w)
            O_STALL: return {1'b0, hif.stall};
            O_D0:    return hif.fwd_d0;
            O_D1:    return hif.fwd_d1;
            O_E0:    return hif.fwd_e0;
            O_E1:    return hif.fwd_e1;
            default: return hif.fwd_m1;
        endcase
    endfunction

    task automatic push_exp(string tag, out_e w, int val);
        exp_t e;
        if (val < 0) return;
        e.tag   = tag;
        e.which = w;
        e.val   = val;
        sb.push_back(e);
    endtask

    // Queue this cycle's expectations; -1 means "not checked".
    task automatic exp_all(string tag, int st, int d0, int d1, int e0, int e1, int m1);
        push_exp({tag, ".stall"},  O_STALL, st);
        push_exp({tag, ".fwd_d0"}, O_D0, d0);
        push_exp({tag, ".fwd_d1"}, O_D1, d1);
        push_exp({tag, ".fwd_e0"}, O_E0, e0);
        push_exp({tag, ".fwd_e1"}, O_E1, e1);
        push_exp({tag, ".fwd_m1"}, O_M1, m1);
    endtask

    task automatic set_d(int ra0, int rs0, int ra1, int rs1, int wa, int ws);
        hif.d_read_addr0  = 5'(ra0);
        hif.d_read_stage0 = 2'(rs0);
        hif.d_read_addr1  = 5'(ra1);
        hif.d_read_stage1 = 2'(rs1);
        hif.d_write_addr  = 5'(wa);
        hif.d_write_stage = 2'(ws);
    endtask

    task automatic set_md(logic start, logic use_md, logic busy);
`ifdef HAZARD_MDU_EN
        hif.d_md_start = start;
        hif.d_md_use   = use_md;
        hif.md_busy    = busy;
`else
        if (start | use_md | busy) $display("note: MDU inputs ignored in this build");
`endif
    endtask

    task automatic nop();
        set_d(0, SX, 0, SX, 0, SD);
        set_md(1'b0, 1'b0, 1'b0);
    endtask

    // Compare everything queued for this cycle at the falling edge, then advance.
    task automatic tick();
        @(negedge clk);
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check_val(e.tag, {30'b0, observe(e.which)}, e.val);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic flush();
        repeat (3) begin
            nop();
            tick();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        nop();
        tick();
        tick();
        reset = 1'b0;
        exp_all("reset", 0, FN, FN, FN, FN, FN);
        tick();

        // 1: lw $8 ; add $9,$8,$8
        set_d(29, SE, 0, SX, 8, SM);
        exp_all("t1_lw", 0, -1, -1, -1, -1, -1);
        tick();
        set_d(8, SE, 8, SE, 9, SE);
        exp_all("t1_stall", 1, FN, FN, -1, -1, -1);
        tick();
        exp_all("t1_release", 0, FN, FN, -1, -1, -1);
        tick();
        nop();
        exp_all("t1_fwd", 0, FN, FN, FW, FW, FN);
        tick();
        flush();

        // 2: addu $8 ; beq $8,$0
        set_d(1, SE, 2, SE, 8, SE);
        exp_all("t2_addu", 0, -1, -1, -1, -1, -1);
        tick();
        set_d(8, SD, 0, SD, 0, SD);
        exp_all("t2_stall", 1, FN, FN, -1, -1, -1);
        tick();
        exp_all("t2_fwd", 0, FM, FN, -1, -1, -1);
        tick();
        flush();

        // 3: lw $8 ; sw $8,0($9)
        set_d(29, SE, 0, SX, 8, SM);
        tick();
        set_d(9, SE, 8, SM, 0, SD);
        exp_all("t3_d", 0, FN, FN, -1, -1, -1);
        tick();
        nop();
        exp_all("t3_e", 0, FN, FN, FN, FN, -1);
        tick();
        exp_all("t3_m", 0, -1, -1, FN, FN, FW);
        tick();
        flush();

        // 4: jal ; jr $31 ; addu $0,$1,$1 ; add $2,$0,$0
        set_d(0, SX, 0, SX, 31, SD);
        exp_all("t4_jal", 0, -1, -1, -1, -1, -1);
        tick();
        set_d(31, SD, 0, SX, 0, SD);
        exp_all("t4_jr", 0, FE, FN, -1, -1, -1);
        tick();
        set_d(1, SE, 1, SE, 0, SE);
        exp_all("t4_addu0", 0, -1, -1, -1, -1, -1);
        tick();
        set_d(0, SE, 0, SE, 2, SE);
        exp_all("t4_zero", 0, FN, FN, -1, -1, -1);
        tick();
        nop();
        exp_all("t4_zero_e", 0, FN, FN, FN, FN, FN);
        tick();
        flush();

        // 5: addu $8 (ends in M) ; ori $8 (ends in E) ; beq $8,$8
        set_d(1, SE, 2, SE, 8, SE);
        tick();
        set_d(3, SE, 0, SX, 8, SE);
        exp_all("t5_ori", 0, -1, -1, -1, -1, -1);
        tick();
        set_d(8, SD, 8, SD, 0, SD);
        exp_all("t5_stall", 1, FN, FN, -1, -1, -1);
        tick();
        exp_all("t5_fwd", 0, FM, FM, -1, -1, -1);
        tick();
        flush();

        // 6: reset in the middle of the lw->add stall
        set_d(29, SE, 0, SX, 8, SM);
        tick();
        set_d(8, SE, 8, SE, 9, SE);
        exp_all("t6_stall", 1, -1, -1, -1, -1, -1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_all("t6_after_reset", 0, FN, FN, FN, FN, FN);
        tick();
        flush();

`ifdef HAZARD_MDU_EN
        // mult ; mfhi with the MDU busy for a while
        set_d(1, SE, 2, SE, 0, SD);
        set_md(1'b1, 1'b1, 1'b0);
        exp_all("md_mult", 0, -1, -1, -1, -1, -1);
        tick();
        set_d(0, SX, 0, SX, 8, SE);
        set_md(1'b0, 1'b1, 1'b0);
        exp_all("md_e_start", 1, -1, -1, -1, -1, -1);
        tick();
        set_md(1'b0, 1'b1, 1'b1);
        exp_all("md_busy1", 1, -1, -1, -1, -1, -1);
        tick();
        exp_all("md_busy2", 1, -1, -1, -1, -1, -1);
        tick();
        set_md(1'b0, 1'b1, 1'b0);
        exp_all("md_release", 0, -1, -1, -1, -1, -1);
        tick();
        flush();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
